ccff_chain_loader: RTL and testbench

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

---
 rtl/ccff_loader_pkg.sv | 15 +
 rtl/ccff_word_serializer.sv | 41 ++++
 rtl/ccff_chain_loader.sv | 138 +++++++++++++
 tb/tb_ccff_chain_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared FSM state type and default sizing for the ccff chain loader.
// One fle configuration is 16 LUT bits plus one mode bit.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    localparam int DEFAULT_CHAIN_LEN = 17;
    localparam int DEFAULT_WORD_W    = 8;

endpackage

// File: rtl/ccff_word_serializer.sv
// Holds one bitstream word and presents it LSB first, counting down the
// bits of this word that still have to reach the chain.
module ccff_word_serializer
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W = DEFAULT_WORD_W
) (
    input  logic                         prog_clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic                         shift,
    input  logic [WORD_W-1:0]            data,
    input  logic [$clog2(WORD_W+1)-1:0]  count,
    output logic                         lsb,
    output logic                         last
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] shift_reg;
    logic [CNT_W-1:0]  left_reg;

    always_ff @(posedge prog_clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            left_reg  <= '0;
        end else if (load) begin
            shift_reg <= data;
            left_reg  <= count;
        end else if (shift && (left_reg != '0)) begin
            shift_reg <= shift_reg >> 1;
            left_reg  <= left_reg - CNT_W'(1);
        end
    end

    assign lsb  = shift_reg[0];
    // Bits beyond the programmed count are never presented, so a short
    // final word simply ends its shift run early.
    assign last = (left_reg == CNT_W'(1));

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams a bitstream into a ccff configuration chain, one word at a time.
// Define CCFF_READBACK_EN to compare the chain tail against the shifted bits.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
    parameter int WORD_W    = DEFAULT_WORD_W
) (
    input  logic              prog_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int WCNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

    loader_state_t     state_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic              cfg_ready_reg;
    logic              shift_en_reg;
    logic              busy_reg;
    logic              done_reg;

    logic [CNT_W-1:0]  bits_left;
    logic [WCNT_W-1:0] word_bits;
    logic              ser_load;
    logic              ser_lsb;
    logic              ser_last;

    // A word carries at most WORD_W bits, fewer when the chain is nearly full.
    assign bits_left = CNT_W'(CHAIN_LEN) - bit_cnt_reg;
    assign word_bits = (32'(bits_left) < 32'(WORD_W)) ? WCNT_W'(bits_left)
                                                      : WCNT_W'(WORD_W);
    assign ser_load  = cfg_ready_reg & cfg_valid;

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_serializer (
        .prog_clk (prog_clk),
        .reset    (reset),
        .load     (ser_load),
        .shift    (shift_en_reg),
        .data     (cfg_data),
        .count    (word_bits),
        .lsb      (ser_lsb),
        .last     (ser_last)
    );

    always_ff @(posedge prog_clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            cfg_ready_reg <= 1'b0;
            shift_en_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg     <= LOAD;
                        bit_cnt_reg   <= '0;
                        busy_reg      <= 1'b1;
                        cfg_ready_reg <= 1'b1;
                    end
                end
                LOAD: begin
                    if (cfg_valid) begin
                        state_reg     <= SHIFT;
                        cfg_ready_reg <= 1'b0;
                        shift_en_reg  <= 1'b1;
                    end
                end
                SHIFT: begin
                    bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                    if (ser_last) begin
                        shift_en_reg <= 1'b0;
                        if (bit_cnt_reg == LAST_IDX) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg     <= LOAD;
                            cfg_ready_reg <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign cfg_ready     = cfg_ready_reg;
    assign ccff_shift_en = shift_en_reg;
    // Leftover word bits sit in the shift register between runs; keep them off the head.
    assign ccff_head     = shift_en_reg & ser_lsb;
    assign busy          = busy_reg;
    assign done          = done_reg;

`ifdef CCFF_READBACK_EN
    logic err_reg;

    // After a full pass the chain tail replays the previous pass bit by bit.
    always_ff @(posedge prog_clk or posedge reset) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else if ((state_reg == IDLE) && start) begin
            err_reg <= 1'b0;
        end else if (shift_en_reg && (ccff_tail != ser_lsb)) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    logic unused_tail;

    assign unused_tail = ccff_tail;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench for ccff_chain_loader: directed and randomized passes
// against a bitstream/chain reference model.
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 17;
    localparam int WORD_W    = 8;
    localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LIMIT     = 60;

    logic              prog_clk = 1'b0;
    logic              reset;
    logic              start;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              ccff_head;
    logic              ccff_tail;
    logic              ccff_shift_en;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    logic [WORD_W-1:0]    pass_words [NWORDS];
    logic                 got_q [$];
    logic [CHAIN_LEN-1:0] chain_model;
    logic [CHAIN_LEN-1:0] last_got_bits;
    int                   shift_cnt    = 0;
    int                   done_cnt     = 0;
    int                   err_rise_idx = -1;
    logic                 exp_err      = 1'b0;
    logic                 clr_req      = 1'b0;
    logic                 prev_shift   = 1'b0;
    logic                 prev_head    = 1'b0;
    logic                 prev_mis     = 1'b0;

    ccff_chain_loader #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W)
    ) dut (
        .prog_clk      (prog_clk),
        .reset         (reset),
        .start         (start),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .ccff_shift_en (ccff_shift_en),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 prog_clk = ~prog_clk;

    assign ccff_tail = chain_model[CHAIN_LEN-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Chain model plus sticky readback expectation, evaluated mid-cycle.
    always @(negedge prog_clk) begin
        if (prev_shift && !reset)
            chain_model = {chain_model[CHAIN_LEN-2:0], prev_head};
        if (reset)
            exp_err = 1'b0;
        else if (clr_req)
            exp_err = 1'b0;
`ifdef CCFF_READBACK_EN
        else if (prev_shift && prev_mis)
            exp_err = 1'b1;
`endif
        check("err", 32'(err), 32'(exp_err));
        if (err && (err_rise_idx < 0))
            err_rise_idx = got_q.size() - 1;
        if (done) begin
            done_cnt++;
            check("busy_at_done", 32'(busy), 32'd0);
        end
        prev_shift = ccff_shift_en && !reset;
        prev_head  = ccff_head;
        prev_mis   = (chain_model[CHAIN_LEN-1] != ccff_head);
        if (ccff_shift_en) begin
            got_q.push_back(ccff_head);
            shift_cnt++;
        end
    end

    task automatic tick();
        @(negedge prog_clk);
        #2;
    endtask

    // One load pass; abort_at >= 0 returns early once that bit index is on the head.
    task automatic run_pass(input int gap_idx, input int gap_len, input bit poke, input int abort_at);
        logic [CHAIN_LEN-1:0] exp_bits;
        logic [CHAIN_LEN-1:0] got_bits;
        int t;
        bit poked;
        poked     = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = WORD_W'($urandom);
        tick();
        check("idle_ready", 32'(cfg_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        got_q.delete();
        shift_cnt = 0;
        done_cnt  = 0;
        start     = 1'b1;
        clr_req   = 1'b1;
        cfg_valid = 1'b0;
        tick();
        start        = 1'b0;
        clr_req      = 1'b0;
        err_rise_idx = -1;
        check("start_busy", 32'(busy), 32'd1);
        check("start_ready", 32'(cfg_ready), 32'd1);
        check("err_clear_on_start", 32'(err), 32'd0);
        for (int i = 0; i < NWORDS; i++) begin
            if ((i == gap_idx) && (gap_len > 0)) begin
                cfg_valid = 1'b0;
                t = 0;
                while (!cfg_ready && (t < LIMIT)) begin
                    tick();
                    t++;
                end
                repeat (gap_len) begin
                    check("stall_shift_en", 32'(ccff_shift_en), 32'd0);
                    check("stall_ready", 32'(cfg_ready), 32'd1);
                    tick();
                end
            end
            cfg_data  = pass_words[i];
            cfg_valid = 1'b1;
            t = 0;
            while (!cfg_ready && (t < LIMIT)) begin
                if ((abort_at >= 0) && (got_q.size() == abort_at) && ccff_shift_en)
                    return;
                if (poke && !poked && ccff_shift_en) begin
                    start = 1'b1;
                    poked = 1'b1;
                end
                tick();
                start = 1'b0;
                t++;
            end
            check("ready_timeout", 32'(t < LIMIT), 32'd1);
            tick();
        end
        cfg_valid = 1'b0;
        t = 0;
        while ((done_cnt == 0) && (t < LIMIT)) begin
            tick();
            t++;
        end
        check("done_timeout", 32'(t < LIMIT), 32'd1);
        repeat (3) tick();
        for (int k = 0; k < CHAIN_LEN; k++) begin
            exp_bits[k] = pass_words[k / WORD_W][k % WORD_W];
            got_bits[k] = (k < got_q.size()) ? got_q[k] : 1'b0;
        end
        last_got_bits = got_bits;
        check("head_seq", 32'(got_bits), 32'(exp_bits));
        check("shift_cnt", 32'(shift_cnt), 32'(CHAIN_LEN));
        check("done_cnt", 32'(done_cnt), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        check("shift_en_after", 32'(ccff_shift_en), 32'd0);
        $display("pass words=%h %h %h gap=%0d/%0d poke=%0d shifts=%0d done=%0d err=%0d",
                 pass_words[0], pass_words[1], pass_words[2], gap_idx, gap_len, poke,
                 shift_cnt, done_cnt, err);
    endtask

    task automatic set_words(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                             input logic [WORD_W-1:0] w2);
        pass_words[0] = w0;
        pass_words[1] = w1;
        pass_words[2] = w2;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        tick();
        check("reset_outputs", 32'({cfg_ready, ccff_head, ccff_shift_en, busy, done, err}), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Back-to-back words with valid held high.
        set_words(8'hA5, 8'h3C, 8'h01);
        run_pass(-1, 0, 1'b0, -1);
        check("req_seq_const", 32'(last_got_bits), 32'h13CA5);

        // Five stall cycles ahead of the second word.
        run_pass(1, 5, 1'b0, -1);
        check("stall_seq_const", 32'(last_got_bits), 32'h13CA5);

        // start while shifting is ignored.
        run_pass(-1, 0, 1'b1, -1);

        // Reset at bit index 10 aborts the pass.
        run_pass(-1, 0, 1'b0, 10);
        check("abort_point", 32'(got_q.size()), 32'd10);
        reset = 1'b1;
        #1;
        check("abort_outputs", 32'({cfg_ready, ccff_head, ccff_shift_en, busy, done, err}), 32'd0);
        cfg_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        run_pass(-1, 0, 1'b0, -1);
        check("restart_seq_const", 32'(last_got_bits), 32'h13CA5);

`ifdef CCFF_READBACK_EN
        run_pass(-1, 0, 1'b0, -1);
        check("rb_same_err", 32'(err), 32'd0);
        set_words(8'hA5, 8'h3D, 8'h01);
        run_pass(-1, 0, 1'b0, -1);
        check("rb_diff_err", 32'(err), 32'd1);
        check("rb_err_idx", 32'(err_rise_idx), 32'd8);
        repeat (4) tick();
        check("rb_err_sticky", 32'(err), 32'd1);
`endif

        for (int n = 0; n < 10; n++) begin
            set_words(WORD_W'($urandom), WORD_W'($urandom), WORD_W'($urandom));
            run_pass($urandom_range(0, 2), $urandom_range(0, 6), 1'($urandom_range(0, 1)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
